// File: rtl/program_counter_stack.sv
// program_counter_stack
// Program counter with a hardware return-address stack (RAS). It drives the
// instruction-fetch address and supports stall, absolute load, signed relative
// branch, CALL (push PC+1 and jump) and RETURN (pop into PC).
//
// Next-PC priority: Reset > Stall > Return > Call > LoadEnable > OffsetEnable > +1.
//
// Ports:
//   Clock, Reset        rising-edge clock, synchronous active-high reset
//   Stall               hold PC and stack this cycle
//   LoadEnable/LoadValue absolute jump; LoadValue is also the call target
//   OffsetEnable/Offset relative branch by sign-extended Offset
//   Call, Return        push PC+1 and jump / pop top of stack into PC
//   CounterValue        current PC
//   StackCount          number of valid RAS entries
//   StackFull/Empty     StackCount == STACK_DEPTH / StackCount == 0
//   StackError          (PC_STACK_ERROR_EN only) sticky overflow/underflow flag
//
// Build option: define PC_STACK_ERROR_EN to suppress Call-when-full, flag both
// overflow and underflow on StackError. Without it, overflow overwrites the
// oldest entry and underflow behaves as a plain increment.
module program_counter_stack #(
    parameter int unsigned     WIDTH        = 16,
    parameter int unsigned     OFFSET_WIDTH = 9,
    parameter int unsigned     STACK_DEPTH  = 8,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                               Clock,
    input  logic                               Reset,
    input  logic                               Stall,
    input  logic                               LoadEnable,
    input  logic [WIDTH-1:0]                   LoadValue,
    input  logic                               OffsetEnable,
    input  logic [OFFSET_WIDTH-1:0]            Offset,
    input  logic                               Call,
    input  logic                               Return,
    output logic [WIDTH-1:0]                   CounterValue,
    output logic [$clog2(STACK_DEPTH):0]       StackCount,
    output logic                               StackFull,
`ifdef PC_STACK_ERROR_EN
    output logic                               StackError,
`endif
    output logic                               StackEmpty
);

    localparam int unsigned PTR_W = $clog2(STACK_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] pc_q,    pc_d;
    logic [PTR_W-1:0] top_q,   top_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q,  empty_q;
    logic             push_c;
    logic [WIDTH-1:0] pc_inc_c;
    logic [WIDTH-1:0] offset_sext_c;
    logic             full_c;
    logic [WIDTH-1:0] stack_q [STACK_DEPTH];
`ifdef PC_STACK_ERROR_EN
    logic             err_q,   err_d;
`endif

    // Next-state decode in priority order
    always_comb begin
        pc_inc_c      = pc_q + WIDTH'(1);
        offset_sext_c = {{(WIDTH-OFFSET_WIDTH){Offset[OFFSET_WIDTH-1]}}, Offset};
        full_c        = (count_q == CNT_W'(STACK_DEPTH));
        pc_d          = pc_inc_c;
        top_d         = top_q;
        count_d       = count_q;
        push_c        = 1'b0;
`ifdef PC_STACK_ERROR_EN
        err_d         = err_q;
`endif
        if (Stall) begin
            pc_d = pc_q;
        end else if (Return) begin
            if (count_q != '0) begin
                pc_d    = stack_q[top_q];
                top_d   = top_q - PTR_W'(1);
                count_d = count_q - CNT_W'(1);
            end else begin
`ifdef PC_STACK_ERROR_EN
                err_d = 1'b1;
`endif
            end
        end else if (Call) begin
`ifdef PC_STACK_ERROR_EN
            if (full_c) begin
                err_d = 1'b1;
            end else begin
                push_c  = 1'b1;
                pc_d    = LoadValue;
                top_d   = top_q + PTR_W'(1);
                count_d = count_q + CNT_W'(1);
            end
`else
            // When full, top+1 lands on the oldest entry so it is overwritten
            push_c  = 1'b1;
            pc_d    = LoadValue;
            top_d   = top_q + PTR_W'(1);
            count_d = full_c ? count_q : count_q + CNT_W'(1);
`endif
        end else if (LoadEnable) begin
            pc_d = LoadValue;
        end else if (OffsetEnable) begin
            pc_d = pc_q + offset_sext_c;
        end
    end

    // Control state register
    always_ff @(posedge Clock) begin
        if (Reset) begin
            pc_q    <= RESET_VECTOR;
            top_q   <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
`ifdef PC_STACK_ERROR_EN
            err_q   <= 1'b0;
`endif
        end else begin
            pc_q    <= pc_d;
            top_q   <= top_d;
            count_q <= count_d;
            full_q  <= (count_d == CNT_W'(STACK_DEPTH));
            empty_q <= (count_d == '0);
`ifdef PC_STACK_ERROR_EN
            err_q   <= err_d;
`endif
        end
    end

    // RAS storage; contents are don't-care after reset so no reset is applied
    always_ff @(posedge Clock) begin
        if (push_c && !Reset) begin
            stack_q[top_q + PTR_W'(1)] <= pc_inc_c;
        end
    end

    assign CounterValue = pc_q;
    assign StackCount   = count_q;
    assign StackFull    = full_q;
    assign StackEmpty   = empty_q;
`ifdef PC_STACK_ERROR_EN
    assign StackError   = err_q;
`endif

endmodule

// File: tb/tb_program_counter_stack.sv
// Directed self-checking bench for program_counter_stack (default parameters).
// Expected values are hand-computed; build-option dependent values are selected
// with PC_STACK_ERROR_EN.
module tb_program_counter_stack;

    logic        Clock;
    logic        Reset;
    logic        Stall;
    logic        LoadEnable;
    logic [15:0] LoadValue;
    logic        OffsetEnable;
    logic [8:0]  Offset;
    logic        Call;
    logic        Return;
    logic [15:0] CounterValue;
    logic [3:0]  StackCount;
    logic        StackFull;
    logic        StackEmpty;
`ifdef PC_STACK_ERROR_EN
    logic        StackError;
`endif

    int checks = 0;
    int passed = 0;
    int failed = 0;

    program_counter_stack dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .Stall        (Stall),
        .LoadEnable   (LoadEnable),
        .LoadValue    (LoadValue),
        .OffsetEnable (OffsetEnable),
        .Offset       (Offset),
        .Call         (Call),
        .Return       (Return),
        .CounterValue (CounterValue),
        .StackCount   (StackCount),
        .StackFull    (StackFull),
`ifdef PC_STACK_ERROR_EN
        .StackError   (StackError),
`endif
        .StackEmpty   (StackEmpty)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic clear_inputs();
        Stall        = 1'b0;
        LoadEnable   = 1'b0;
        LoadValue    = 16'h0000;
        OffsetEnable = 1'b0;
        Offset       = 9'h000;
        Call         = 1'b0;
        Return       = 1'b0;
    endtask

    task automatic load_pc(input logic [15:0] v);
        clear_inputs();
        LoadEnable = 1'b1;
        LoadValue  = v;
        tick();
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        Reset = 1'b1;

        // 1. reset and idle increment
        tick();
        tick();
        check("rst_pc", 32'(CounterValue), 32'h0);
        check("rst_cnt", 32'(StackCount), 32'h0);
        check("rst_empty", 32'(StackEmpty), 32'h1);
        check("rst_full", 32'(StackFull), 32'h0);
`ifdef PC_STACK_ERROR_EN
        check("rst_err", 32'(StackError), 32'h0);
`endif
        Reset = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("idle_pc", 32'(CounterValue), 32'(i));
        end

        // 2. relative branch and wrap
        load_pc(16'h0010);
        check("load_pc", 32'(CounterValue), 32'h0010);
        OffsetEnable = 1'b1;
        Offset       = 9'h1FD;
        tick();
        check("off_neg", 32'(CounterValue), 32'h000D);
        Offset = 9'h0FF;
        tick();
        check("off_pos", 32'(CounterValue), 32'h010C);
        load_pc(16'hFFFF);
        tick();
        check("inc_wrap", 32'(CounterValue), 32'h0000);

        // 3. single call / return
        load_pc(16'h0020);
        Call      = 1'b1;
        LoadValue = 16'h0400;
        tick();
        clear_inputs();
        check("call_pc", 32'(CounterValue), 32'h0400);
        check("call_cnt", 32'(StackCount), 32'h1);
        check("call_empty", 32'(StackEmpty), 32'h0);
        tick();
        tick();
        check("sub_pc", 32'(CounterValue), 32'h0402);
        Return = 1'b1;
        tick();
        clear_inputs();
        check("ret_pc", 32'(CounterValue), 32'h0021);
        check("ret_empty", 32'(StackEmpty), 32'h1);
        check("ret_cnt", 32'(StackCount), 32'h0);

        // 4. nested calls to full, then overflow
        load_pc(16'h0100);
        for (int i = 0; i < 8; i++) begin
            Call      = 1'b1;
            LoadValue = 16'(16'h0101 + i);
            tick();
            check("nest_pc", 32'(CounterValue), 32'(16'h0101 + i));
        end
        clear_inputs();
        check("nest_cnt", 32'(StackCount), 32'h8);
        check("nest_full", 32'(StackFull), 32'h1);
        Call      = 1'b1;
        LoadValue = 16'h0300;
        tick();
        clear_inputs();
        check("ovf_cnt", 32'(StackCount), 32'h8);
`ifdef PC_STACK_ERROR_EN
        check("ovf_pc", 32'(CounterValue), 32'h0109);
        check("ovf_err", 32'(StackError), 32'h1);
        for (int i = 0; i < 8; i++) begin
            Return = 1'b1;
            tick();
            check("unwind_pc", 32'(CounterValue), 32'(16'h0108 - i));
        end
`else
        check("ovf_pc", 32'(CounterValue), 32'h0300);
        for (int i = 0; i < 8; i++) begin
            Return = 1'b1;
            tick();
            check("unwind_pc", 32'(CounterValue), 32'(16'h0109 - i));
        end
`endif
        clear_inputs();
        check("unwind_empty", 32'(StackEmpty), 32'h1);
        check("unwind_full", 32'(StackFull), 32'h0);

        // 5. stall holds everything; Call+Return pops only; Return when empty
        load_pc(16'h0500);
        Call      = 1'b1;
        LoadValue = 16'h0600;
        tick();
        check("c5_pc", 32'(CounterValue), 32'h0600);
        Stall     = 1'b1;
        LoadValue = 16'h0700;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_pc", 32'(CounterValue), 32'h0600);
            check("stall_cnt", 32'(StackCount), 32'h1);
        end
        Stall  = 1'b0;
        Return = 1'b1;
        tick();
        clear_inputs();
        check("cr_pc", 32'(CounterValue), 32'h0501);
        check("cr_cnt", 32'(StackCount), 32'h0);
        check("cr_empty", 32'(StackEmpty), 32'h1);
        Return = 1'b1;
        tick();
        clear_inputs();
        check("unf_pc", 32'(CounterValue), 32'h0502);
        check("unf_cnt", 32'(StackCount), 32'h0);
`ifdef PC_STACK_ERROR_EN
        check("unf_err", 32'(StackError), 32'h1);
`endif

        // 6. reset after a call discards the stack
        Call      = 1'b1;
        LoadValue = 16'h0800;
        tick();
        clear_inputs();
        check("c6_cnt", 32'(StackCount), 32'h1);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check("r6_pc", 32'(CounterValue), 32'h0);
        check("r6_cnt", 32'(StackCount), 32'h0);
        check("r6_empty", 32'(StackEmpty), 32'h1);
`ifdef PC_STACK_ERROR_EN
        check("r6_err", 32'(StackError), 32'h0);
`endif
        Return = 1'b1;
        tick();
        clear_inputs();
        check("r6_ret_pc", 32'(CounterValue), 32'h1);
        check("r6_ret_cnt", 32'(StackCount), 32'h0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
